// File: rtl/video_pkg.sv
// Shared types and constants for the gray -> AXI4-Stream video output path.
package video_pkg;

    localparam int unsigned GRAY_WIDTH_DEF = 8;
    localparam int unsigned AXI_WIDTH_DEF  = 24;

    // Byte lane offsets inside the packed 24-bit video beat
    localparam int unsigned R_LSB = 0;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_LSB = 16;

    // Colour used to flag over-threshold pixels when the overlay is built in
    localparam logic [23:0] OVL_COLOR = 24'h00FF00;

    // One buffered beat: packed pixel plus framing flags decided at accept time
    typedef struct packed {
        logic [23:0] data;
        logic        tuser;
        logic        tlast;
        logic        eof;
    } fifo_entry_t;

    localparam int unsigned ENTRY_WIDTH = $bits(fifo_entry_t);

    // Replicate one gray byte into all three colour lanes
    function automatic logic [23:0] replicate_gray(input logic [7:0] g);
        logic [23:0] p;
        p              = '0;
        p[R_LSB +: 8]  = g;
        p[G_LSB +: 8]  = g;
        p[B_LSB +: 8]  = g;
        return p;
    endfunction

endpackage

// File: rtl/gray_axis_skid_fifo.sv
// Two-entry FIFO that decouples the pixel input from AXI backpressure.
// Pushes into a full FIFO and pops from an empty one are ignored.
module gray_axis_skid_fifo
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  fifo_entry_t wr_entry,
    output fifo_entry_t head,
    output logic [1:0]  count
);

    logic [ENTRY_WIDTH-1:0] mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = fifo_entry_t'(mem[rd_ptr]);

    // Storage, pointers and occupancy; reset discards any buffered beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (do_pop && !do_push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/gray_axis_video_tx.sv
// Gray pixel -> AXI4-Stream video transmitter with SOF (tuser) / EOL (tlast) framing.
// Optional build macro LANE_OVERLAY_EN: pixels >= OVL_THRESHOLD are sent as pure green.
module gray_axis_video_tx
    import video_pkg::*;
#(
    parameter int unsigned AXI_WIDTH     = AXI_WIDTH_DEF,
    parameter int unsigned GRAY_WIDTH    = GRAY_WIDTH_DEF,
    parameter int unsigned FRAME_WIDTH   = 640,
    parameter int unsigned FRAME_HEIGHT  = 480,
    parameter int unsigned OVL_THRESHOLD = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GRAY_WIDTH-1:0] gray_pixel,
    input  logic                  valid,
    output logic                  ready,
    output logic [AXI_WIDTH-1:0]  m_axis_video_tdata,
    output logic                  m_axis_video_tvalid,
    input  logic                  m_axis_video_tready,
    output logic                  m_axis_video_tuser,
    output logic                  m_axis_video_tlast,
    output logic                  frame_done
);

    localparam int unsigned COL_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int unsigned ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(FRAME_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(FRAME_HEIGHT - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             init_done;
    logic [1:0]       count;
    logic             accept;
    logic             transfer;
    logic             col_last;
    logic             row_last;
    logic [7:0]       gray8;
    fifo_entry_t      new_entry;
    fifo_entry_t      head;

    // ready stays low until the first edge after reset release
    assign ready               = init_done && (count != 2'd2);
    assign m_axis_video_tvalid = (count != 2'd0);
    assign accept              = valid && ready;
    assign transfer            = m_axis_video_tvalid && m_axis_video_tready;
    assign col_last            = (col == COL_MAX);
    assign row_last            = (row == ROW_MAX);

    // Narrow or widen the incoming pixel to one byte, keeping the MSBs
    if (GRAY_WIDTH >= 8) begin : g_gray_msb
        assign gray8 = gray_pixel[GRAY_WIDTH-1 -: 8];
    end else begin : g_gray_pad
        assign gray8 = {gray_pixel, {(8 - GRAY_WIDTH){1'b0}}};
    end

    // Pack the pixel and decide its framing flags at accept time
    always_comb begin
        new_entry.data = replicate_gray(gray8);
`ifdef LANE_OVERLAY_EN
        if (gray_pixel >= GRAY_WIDTH'(OVL_THRESHOLD)) begin
            new_entry.data = OVL_COLOR;
        end
`endif
        new_entry.tuser = (col == '0) && (row == '0);
        new_entry.tlast = col_last;
        new_entry.eof   = col_last && row_last;
    end

    // One-shot flag that opens the input after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // Column/row position of the next accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Pulse the cycle after the final beat of a frame leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= transfer && head.eof;
        end
    end

    gray_axis_skid_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .pop      (transfer),
        .wr_entry (new_entry),
        .head     (head),
        .count    (count)
    );

    // Drive the stream from the FIFO head; idle bus reads as zero
    always_comb begin
        m_axis_video_tdata        = '0;
        m_axis_video_tuser        = 1'b0;
        m_axis_video_tlast        = 1'b0;
        if (m_axis_video_tvalid) begin
            m_axis_video_tdata[23:0] = head.data;
            m_axis_video_tuser       = head.tuser;
            m_axis_video_tlast       = head.tlast;
        end
    end

endmodule
